sync_event_detect: RTL and testbench

SYNC_EVENT_DETECT -- requirements
Module: sync_event_detect

---
 rtl/sync_event_pkg.sv | 32 +++
 rtl/sync_event_ch.sv | 102 ++++++++++
 rtl/sync_event_detect.sv | 70 +++++++
 tb/tb_sync_event_detect.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_event_pkg.sv
// Shared types and limits for the synchronizing edge/event detector.
package sync_event_pkg;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_BOTH = 2'd2
    } edge_mode_t;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;
    localparam int N_CH_MIN        = 1;
    localparam int N_CH_MAX        = 32;

    // Per-channel status bundle handed from a channel to the top.
    typedef struct packed {
        logic pulse;
        logic sticky;
        logic sticky_nxt;
        logic overrun;
    } ch_stat_t;

    // 0 and 1 both mean "accept the first differing sample".
    function automatic int deb_eff(input int d);
        return (d < 1) ? 1 : d;
    endfunction

    function automatic int cnt_w(input int d);
        return (d <= 1) ? 1 : $clog2(d + 1);
    endfunction

endpackage

// File: rtl/sync_event_ch.sv
// One channel: synchronizer, debounce filter, edge detect, sticky/overrun flags.
module sync_event_ch
    import sync_event_pkg::*;
#(
    parameter int         SYNC_STAGES     = 2,
    parameter bit         POLARITY        = 1'b0,
    parameter edge_mode_t EDGE_MODE       = EDGE_RISE,
    parameter int         DEBOUNCE_CYCLES = 0,
    parameter bit         OUT_REG         = 1'b1
) (
    input  logic     clk,
    input  logic     rstn,
    input  logic     async_in,
    input  logic     clr,
    output ch_stat_t stat
);

    localparam int            DEB      = deb_eff(DEBOUNCE_CYCLES);
    localparam int            CW       = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    (* async_reg = "true" *) logic meta_q;
    logic [SYNC_STAGES-1:1] tail_q;
    logic                   lvl;
    logic                   stable_q, stable_dly_q;
    logic [CW-1:0]          cnt_q;
    logic                   rise, fall, evt;
    logic                   sticky_q, overrun_q, sticky_d, overrun_d;
    logic                   pulse;

    // Chain resets to the inactive input level so release never fakes an edge.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            meta_q <= POLARITY;
            tail_q <= {(SYNC_STAGES-1){POLARITY}};
        end else begin
            meta_q    <= async_in;
            tail_q[1] <= meta_q;
            for (int i = 2; i < SYNC_STAGES; i++) tail_q[i] <= tail_q[i-1];
        end
    end

    assign lvl = tail_q[SYNC_STAGES-1] ^ POLARITY;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            stable_dly_q <= stable_q;
            if (lvl == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                stable_q <= lvl;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_ONE;
            end
        end
    end

    always_comb begin
        rise = stable_q & ~stable_dly_q;
        fall = ~stable_q & stable_dly_q;
        evt  = rise;
        case (EDGE_MODE)
            EDGE_FALL: evt = fall;
            EDGE_BOTH: evt = rise | fall;
            default:   evt = rise;
        endcase
    end

    // Set beats clear on both flags.
    assign sticky_d  = evt | (sticky_q & ~clr);
    assign overrun_d = (evt & sticky_q) | (overrun_q & ~clr);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sticky_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            sticky_q  <= sticky_d;
            overrun_q <= overrun_d;
        end
    end

    if (OUT_REG) begin : g_oreg
        logic pulse_q;
        always_ff @(posedge clk) begin
            if (!rstn) pulse_q <= POLARITY;
            else       pulse_q <= evt ^ POLARITY;
        end
        assign pulse = pulse_q;
    end else begin : g_ocomb
        assign pulse = evt ^ POLARITY;
    end

    assign stat = '{pulse: pulse, sticky: sticky_q, sticky_nxt: sticky_d, overrun: overrun_q};

endmodule

// File: rtl/sync_event_detect.sv
// Multi-channel async level synchronizer with debounce and one-shot event output.
module sync_event_detect
    import sync_event_pkg::*;
#(
    parameter int         N_CH            = 4,
    parameter int         SYNC_STAGES     = 2,
    parameter int         POLARITY        = 0,
    parameter edge_mode_t EDGE_MODE       = EDGE_RISE,
    parameter int         DEBOUNCE_CYCLES = 0,
    parameter int         OUT_REG         = 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [N_CH-1:0] async_in,
    input  logic [N_CH-1:0] clr,
    output logic [N_CH-1:0] out_pulse,
    output logic [N_CH-1:0] sticky,
    output logic [N_CH-1:0] overrun,
    output logic            any_event
);

    if (N_CH < N_CH_MIN || N_CH > N_CH_MAX) begin : g_bad_nch
        $error("sync_event_detect: N_CH %0d outside 1..32", N_CH);
    end
    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
        $error("sync_event_detect: SYNC_STAGES %0d outside 2..4", SYNC_STAGES);
    end
    if (POLARITY != 0 && POLARITY != 1) begin : g_bad_pol
        $error("sync_event_detect: POLARITY must be 0 or 1");
    end
    if (OUT_REG != 0 && OUT_REG != 1) begin : g_bad_oreg
        $error("sync_event_detect: OUT_REG must be 0 or 1");
    end
    if (DEBOUNCE_CYCLES < 0) begin : g_bad_deb
        $error("sync_event_detect: DEBOUNCE_CYCLES must be >= 0");
    end
    if (EDGE_MODE != EDGE_RISE && EDGE_MODE != EDGE_FALL && EDGE_MODE != EDGE_BOTH) begin : g_bad_mode
        $error("sync_event_detect: illegal EDGE_MODE");
    end

    ch_stat_t [N_CH-1:0] stat;
    logic     [N_CH-1:0] sticky_nxt;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        sync_event_ch #(
            .SYNC_STAGES     (SYNC_STAGES),
            .POLARITY        (POLARITY[0]),
            .EDGE_MODE       (EDGE_MODE),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .OUT_REG         (OUT_REG[0])
        ) u_ch (
            .clk      (clk),
            .rstn     (rstn),
            .async_in (async_in[g]),
            .clr      (clr[g]),
            .stat     (stat[g])
        );
        assign out_pulse[g]  = stat[g].pulse;
        assign sticky[g]     = stat[g].sticky;
        assign overrun[g]    = stat[g].overrun;
        assign sticky_nxt[g] = stat[g].sticky_nxt;
    end

    // Built from next-state sticky so it rises and falls with the sticky bits.
    always_ff @(posedge clk) begin
        if (!rstn) any_event <= 1'b0;
        else       any_event <= |sticky_nxt;
    end

endmodule

// File: tb/tb_sync_event_detect.sv
// Randomized + directed bench for sync_event_detect over four parameter sets.
module tb_sync_event_detect;
    import sync_event_pkg::*;

    localparam int NI = 4;
    // A: debounce/rise   B: active-low both   C: plain rise   D: active-low fall, deep sync
    localparam int A_NCH = 8, A_S = 2, A_POL = 0, A_DEB = 4, A_OREG = 1;
    localparam int B_NCH = 4, B_S = 3, B_POL = 1, B_DEB = 0, B_OREG = 0;
    localparam int C_NCH = 3, C_S = 2, C_POL = 0, C_DEB = 0, C_OREG = 1;
    localparam int D_NCH = 2, D_S = 4, D_POL = 1, D_DEB = 2, D_OREG = 0;

    int p_nch  [NI] = '{A_NCH, B_NCH, C_NCH, D_NCH};
    int p_s    [NI] = '{A_S, B_S, C_S, D_S};
    int p_pol  [NI] = '{A_POL, B_POL, C_POL, D_POL};
    int p_deb  [NI] = '{A_DEB, B_DEB, C_DEB, D_DEB};
    int p_oreg [NI] = '{A_OREG, B_OREG, C_OREG, D_OREG};
    int p_mode [NI] = '{0, 2, 0, 1};   // 0 rise, 1 fall, 2 both

    logic clk = 1'b0;
    logic rstn;
    logic [NI-1:0][7:0] ain, cl;
    logic [NI-1:0][7:0] obs_op, obs_stk, obs_ovr;
    logic [NI-1:0]      obs_any;

    logic [A_NCH-1:0] a_op, a_stk, a_ovr;
    logic [B_NCH-1:0] b_op, b_stk, b_ovr;
    logic [C_NCH-1:0] c_op, c_stk, c_ovr;
    logic [D_NCH-1:0] d_op, d_stk, d_ovr;

    always #5 clk = ~clk;

    sync_event_detect #(.N_CH(A_NCH), .SYNC_STAGES(A_S), .POLARITY(A_POL), .EDGE_MODE(EDGE_RISE),
                        .DEBOUNCE_CYCLES(A_DEB), .OUT_REG(A_OREG)) u_a (
        .clk(clk), .rstn(rstn), .async_in(ain[0][A_NCH-1:0]), .clr(cl[0][A_NCH-1:0]),
        .out_pulse(a_op), .sticky(a_stk), .overrun(a_ovr), .any_event(obs_any[0]));
    sync_event_detect #(.N_CH(B_NCH), .SYNC_STAGES(B_S), .POLARITY(B_POL), .EDGE_MODE(EDGE_BOTH),
                        .DEBOUNCE_CYCLES(B_DEB), .OUT_REG(B_OREG)) u_b (
        .clk(clk), .rstn(rstn), .async_in(ain[1][B_NCH-1:0]), .clr(cl[1][B_NCH-1:0]),
        .out_pulse(b_op), .sticky(b_stk), .overrun(b_ovr), .any_event(obs_any[1]));
    sync_event_detect #(.N_CH(C_NCH), .SYNC_STAGES(C_S), .POLARITY(C_POL), .EDGE_MODE(EDGE_RISE),
                        .DEBOUNCE_CYCLES(C_DEB), .OUT_REG(C_OREG)) u_c (
        .clk(clk), .rstn(rstn), .async_in(ain[2][C_NCH-1:0]), .clr(cl[2][C_NCH-1:0]),
        .out_pulse(c_op), .sticky(c_stk), .overrun(c_ovr), .any_event(obs_any[2]));
    sync_event_detect #(.N_CH(D_NCH), .SYNC_STAGES(D_S), .POLARITY(D_POL), .EDGE_MODE(EDGE_FALL),
                        .DEBOUNCE_CYCLES(D_DEB), .OUT_REG(D_OREG)) u_d (
        .clk(clk), .rstn(rstn), .async_in(ain[3][D_NCH-1:0]), .clr(cl[3][D_NCH-1:0]),
        .out_pulse(d_op), .sticky(d_stk), .overrun(d_ovr), .any_event(obs_any[3]));

    assign obs_op[0] = 8'(a_op);  assign obs_stk[0] = 8'(a_stk);  assign obs_ovr[0] = 8'(a_ovr);
    assign obs_op[1] = 8'(b_op);  assign obs_stk[1] = 8'(b_stk);  assign obs_ovr[1] = 8'(b_ovr);
    assign obs_op[2] = 8'(c_op);  assign obs_stk[2] = 8'(c_stk);  assign obs_ovr[2] = 8'(c_ovr);
    assign obs_op[3] = 8'(d_op);  assign obs_stk[3] = 8'(d_stk);  assign obs_ovr[3] = 8'(d_ovr);

    // Reference model: active level history per edge; stable flips once the last
    // max(DEB,1) synchronized samples all disagree with it and none predate the
    // previous flip or reset.
    logic hist  [NI][8][64];
    logic m_st  [NI][8];
    logic m_stk [NI][8];
    logic m_ovr [NI][8];
    logic m_evp [NI][8];
    logic m_out [NI][8];
    int   m_last[NI][8];
    int   ecnt;
    int   n_chk, n_fail;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, ecnt);
        end
    endtask

    function automatic logic [7:0] idle(input int i);
        return (p_pol[i] != 0) ? 8'hff : 8'h00;
    endfunction

    function automatic void model_update();
        for (int i = 0; i < NI; i++) begin
            for (int c = 0; c < p_nch[i]; c++) begin
                logic pol, old, nw, ev, flip;
                int   d;
                pol = (p_pol[i] != 0);
                d   = (p_deb[i] < 1) ? 1 : p_deb[i];
                hist[i][c][ecnt & 63] = rstn ? (ain[i][c] ^ pol) : 1'b0;
                if (!rstn) begin
                    m_st[i][c]   = 1'b0;
                    m_last[i][c] = ecnt;
                    m_stk[i][c]  = 1'b0;
                    m_ovr[i][c]  = 1'b0;
                    m_evp[i][c]  = 1'b0;
                    m_out[i][c]  = pol;
                end else begin
                    old  = m_st[i][c];
                    flip = (ecnt - m_last[i][c] >= d);
                    for (int j = 0; j < d; j++)
                        if (hist[i][c][(ecnt - p_s[i] - j) & 63] == old) flip = 1'b0;
                    nw = flip ? ~old : old;
                    if (flip) m_last[i][c] = ecnt;
                    case (p_mode[i])
                        0:       ev = nw & ~old;
                        1:       ev = ~nw & old;
                        default: ev = nw ^ old;
                    endcase
                    m_out[i][c] = (p_oreg[i] != 0) ? (m_evp[i][c] ^ pol) : (ev ^ pol);
                    m_ovr[i][c] = (m_evp[i][c] & m_stk[i][c]) | (m_ovr[i][c] & ~cl[i][c]);
                    m_stk[i][c] = m_evp[i][c] | (m_stk[i][c] & ~cl[i][c]);
                    m_evp[i][c] = ev;
                    m_st[i][c]  = nw;
                end
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        ecnt++;
        model_update();
        for (int i = 0; i < NI; i++) begin
            logic [7:0] eop, estk, eovr;
            eop = '0; estk = '0; eovr = '0;
            for (int c = 0; c < p_nch[i]; c++) begin
                eop[c]  = m_out[i][c];
                estk[c] = m_stk[i][c];
                eovr[c] = m_ovr[i][c];
            end
            chk($sformatf("i%0d_pulse", i), obs_op[i], eop);
            chk($sformatf("i%0d_sticky", i), obs_stk[i], estk);
            chk($sformatf("i%0d_overrun", i), obs_ovr[i], eovr);
            chk($sformatf("i%0d_any", i), obs_any[i], |estk);
        end
    endtask

    initial begin
        int k, seen, npul, nhit, rh;
        n_chk = 0; n_fail = 0; ecnt = 0;
        for (int i = 0; i < NI; i++)
            for (int c = 0; c < 8; c++) begin
                m_st[i][c] = 0; m_stk[i][c] = 0; m_ovr[i][c] = 0; m_evp[i][c] = 0;
                m_out[i][c] = 0; m_last[i][c] = 0;
                for (int e = 0; e < 64; e++) hist[i][c][e] = 1'b0;
            end
        rstn = 1'b0;
        for (int i = 0; i < NI; i++) begin ain[i] = idle(i); cl[i] = '0; end
        repeat (5) step();
        chk("rst_pulse_a", obs_op[0], 8'h00);
        chk("rst_pulse_b", obs_op[1], 8'h0f);
        chk("rst_sticky_a", obs_stk[0], 8'h00);
        rstn = 1'b1;
        repeat (8) step();

        // Plain rise, two-stage sync: out_pulse on the third edge after the first sample.
        ain[2][0] = 1'b1; k = ecnt + 1; seen = -1; npul = 0;
        for (int n = 0; n < 8; n++) begin
            step();
            if (obs_op[2][0]) begin npul++; if (seen < 0) seen = ecnt; end
        end
        chk("r37_latency", seen - k, 3);
        chk("r37_count", npul, 1);
        chk("r37_sticky", obs_stk[2][0], 1);
        ain[2][0] = 1'b0; repeat (4) step();

        // Debounce 4: a 3-cycle glitch is swallowed, a 4-cycle hold is accepted.
        npul = 0; ain[0][1] = 1'b1;
        for (int n = 0; n < 13; n++) begin
            if (n == 3) ain[0][1] = 1'b0;
            step(); npul += int'(obs_op[0][1]);
        end
        chk("r38_glitch", npul, 0);
        ain[0][1] = 1'b1; k = ecnt + 1; seen = -1; npul = 0;
        for (int n = 0; n < 18; n++) begin
            if (n == 4) ain[0][1] = 1'b0;
            step();
            if (obs_op[0][1]) begin npul++; if (seen < 0) seen = ecnt; end
        end
        chk("r38_latency", seen - k, 6);
        chk("r38_count", npul, 1);

        // Active-low, both edges: two low-going pulses for one low/high excursion.
        npul = 0; ain[1][0] = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (n == 10) ain[1][0] = 1'b1;
            step(); npul += int'(!obs_op[1][0]);
        end
        chk("r39_pulses", npul, 2);

        // Sticky/overrun on channel 2, then clear coincident with a third event.
        repeat (2) begin
            ain[0][2] = 1'b1; repeat (6) step();
            ain[0][2] = 1'b0; repeat (6) step();
        end
        chk("r40_sticky", obs_stk[0][2], 1);
        chk("r40_overrun", obs_ovr[0][2], 1);
        ain[0][2] = 1'b1;
        for (int n = 0; n < 12; n++) begin
            if (n == 6) ain[0][2] = 1'b0;
            step();
            cl[0][2] = m_evp[0][2];
        end
        cl[0][2] = 1'b0;
        chk("r40_clr_ev_sticky", obs_stk[0][2], 1);
        chk("r40_clr_ev_overrun", obs_ovr[0][2], 1);
        cl[0] = 8'hff; step(); cl[0] = 8'h00;
        chk("r40_clr_sticky", obs_stk[0][2], 0);
        chk("r40_clr_overrun", obs_ovr[0][2], 0);
        chk("r40_clr_any", obs_any[0], 0);

        // All eight channels rise together.
        ain[0] = 8'hff; nhit = 0;
        for (int n = 0; n < 10; n++) begin
            step();
            if (obs_op[0] != 8'h00) begin nhit++; chk("r41_all", obs_op[0], 8'hff); end
        end
        chk("r41_hits", nhit, 1);
        chk("r41_any", obs_any[0], 1);
        ain[0] = 8'h00; repeat (8) step();
        cl[0] = 8'hff; step(); cl[0] = 8'h00;

        // Reset in the middle of a debounce count, input held through release.
        ain[0][3] = 1'b1; npul = 0;
        repeat (4) begin step(); npul += int'(obs_op[0][3]); end
        rstn = 1'b0;
        repeat (3) begin step(); npul += int'(obs_op[0][3]); end
        chk("r42_no_pulse", npul, 0);
        rstn = 1'b1; k = ecnt + 1; seen = -1; npul = 0;
        for (int n = 0; n < 12; n++) begin
            step();
            if (obs_op[0][3]) begin npul++; if (seen < 0) seen = ecnt; end
        end
        chk("r42_latency", seen - k, 6);
        chk("r42_count", npul, 1);

        // Random toggling, clears and occasional resets against the model.
        rh = 0;
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NI; i++) begin
                for (int c = 0; c < 8; c++)
                    if ($urandom_range(3) == 0) ain[i][c] = ~ain[i][c];
                cl[i] = 8'($urandom) & 8'($urandom) & 8'($urandom);
            end
            if (rh > 0) begin rstn = 1'b0; rh--; end
            else if ($urandom_range(299) == 0) begin rstn = 1'b0; rh = 4; end
            else rstn = 1'b1;
            step();
        end
        rstn = 1'b1;
        for (int i = 0; i < NI; i++) begin ain[i] = idle(i); cl[i] = '0; end
        repeat (20) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
